mul_unit: RTL
=============

// Module: mul_unit
// PURPOSE
//  Memory-mapped iterative shift-add multiplier peripheral on the CPU data bus (DA/DD/RW).
//  Replaces the software shift-add multiply loop (e.g. D2 = D0*D1) with one started by a single store.
//  Sits beside data memory; the address decoder routes DA hits in [BASE, BASE+4] here.
//  Generalises width and adds signed mode, early termination, status and overrun flagging.
// PARAMETERS
//  WIDTH   16   operand width; result is 2*WIDTH bits
//  AW      16   data address width (matches DA)
//  BASE    'h70 first register address; aligned to 8
//  SIGNED  0    0 = unsigned, 1 = two's-complement operands
// PORTS
//  CK     in   1        clock; all state updates on posedge
//  RST    in   1        reset, synchronous, active-high
//  DA     in   AW       data address from CPU
//  DDI    in   WIDTH    write data (CPU DD when RW=0)
//  DDO    out  WIDTH    read data (driven onto DD by the top level when RW=1 and SEL=1)
//  RW     in   1        1 = read, 0 = write
//  SEL    out  1        DA in [BASE, BASE+4]; combinational
//  BUSY   out  1        multiply in progress
//  IRQ    out  1        one-cycle pulse when a result becomes valid
// BEHAVIOUR
//  Register map (offset from BASE):
//   0 OPA  rw  multiplicand
//   1 OPB  rw  multiplier; a write starts a multiply
//   2 RESL r   result[WIDTH-1:0]
//   3 RESH r   result[2*WIDTH-1:WIDTH]
//   4 STAT r/w [0]=BUSY [1]=DONE [2]=OVR; any write clears DONE and OVR
//  Reset (RST=1 at posedge): OPA=OPB=0, result=0, BUSY=0, DONE=0, OVR=0, IRQ=0, FSM=IDLE.
//   Reset mid-multiply aborts it; no IRQ is emitted.
//  Reads: DDO = mux of current register state on DA; combinational, zero latency.
//   Unmapped offsets 5..7 read 0, writes to them ignored, SEL=0 there.
//  Writes are captured at posedge when RW=0 and SEL=1; RESL/RESH writes ignored.
//  FSM: IDLE -> (OPB write) LOAD -> RUN -> [FIX if SIGNED] -> IDLE
//   LOAD: acc=0; mcand = zero-extended |OPA| to 2*WIDTH; mplr = |OPB|; neg = signA^signB (SIGNED=1 only);
//    cnt=0; BUSY=1; DONE=0.
//   RUN, per cycle: if mplr[0] then acc += mcand; mcand <<= 1; mplr >>= 1; cnt++.
//    Exit RUN when the shifted mplr==0 or cnt==WIDTH-1 (early termination).
//   FIX (SIGNED=1 only): result = neg ? -acc : acc. When SIGNED=0, the result is acc on RUN exit.
//   On completion: result registers load, BUSY=0, DONE=1, IRQ pulses for exactly one cycle.
//  Latency, OPB write edge to DONE visible:
//   1 (LOAD) + (index of MSB of |OPB|, plus 1) + SIGNED cycles. OPB=0 takes 1 RUN cycle.
//   Worst case WIDTH+1+SIGNED cycles.
//  Widths: all arithmetic in 2*WIDTH bits, no overflow possible.
//   SIGNED: |-2^(WIDTH-1)| is held in WIDTH bits unsigned; correct.
//  While BUSY: writes to OPA/OPB are ignored and set OVR (sticky); the running multiply is unaffected.
//  Simultaneous events: an OPB write on the completion edge is accepted only if BUSY=0 at that edge.
//   So it is ignored and sets OVR.
//  RESL/RESH hold the previous result until a new completion overwrites both on the same edge.
// STRUCTURE
//  Shared package mul_pkg: register offset constants (OFF_OPA..OFF_STAT), STAT bit indices,
//   FSM state encoding (IDLE, LOAD, RUN, FIX).
//  Sub-module mul_datapath: acc/mcand/mplr registers, adder and shifters, with done_cond output.
//  mul_unit owns the address decode, register file, FSM, flags and IRQ.
// TESTING
//  1 RST high 5 cycles -> BUSY=0, STAT=0, RESL=RESH=0, IRQ never asserted.
//  2 write OPA=5, OPB=15 -> BUSY for 5 cycles, IRQ 1 cycle, RESL=75, RESH=0, STAT=2.
//  3 OPA=16'hFFFF, OPB=16'hFFFF, SIGNED=0 -> RESH=16'hFFFE, RESL=16'h0001, latency 17.
//  4 SIGNED=1: OPA=-3 (16'hFFFD), OPB=7 -> RESL=16'hFFEB, RESH=16'hFFFF.
//    OPA=16'h8000, OPB=16'h8000 -> RESH=16'h4000, RESL=0.
//  5 OPB=0 -> DONE after 2 cycles, result 0. Write OPA during busy -> OVR=1, result unaffected.
//    Then write STAT -> OVR=0, DONE=0.
//  6 assert RST mid-RUN -> next cycle BUSY=0, no IRQ, results 0. New 5*15 afterwards -> 75.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the memory-mapped shift-add multiplier.
//   - register offsets within the 8-word window at BASE
//   - bit positions inside the STAT register
//   - FSM state encoding used by mul_unit
package mul_pkg;

  localparam logic [2:0] OFF_OPA  = 3'd0;
  localparam logic [2:0] OFF_OPB  = 3'd1;
  localparam logic [2:0] OFF_RESL = 3'd2;
  localparam logic [2:0] OFF_RESH = 3'd3;
  localparam logic [2:0] OFF_STAT = 3'd4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/mul_datapath.sv
// Iterative shift-add core for mul_unit.
// Ports:
//   clk        clock
//   load       initialise acc/mcand/mplr/cnt from the operand magnitudes
//   run        perform one shift-add step
//   mcand_in   multiplicand magnitude (zero-extended internally to 2*WIDTH)
//   mplr_in    multiplier magnitude
//   acc        accumulated partial product
//   acc_next   accumulator value after the current step (valid while running)
//   done_cond  the current step is the last one
// The registers here are fully initialised by load before use, so they carry
// no reset.
module mul_datapath #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic                 run,
  input  logic [WIDTH-1:0]     mcand_in,
  input  logic [WIDTH-1:0]     mplr_in,
  output logic [2*WIDTH-1:0]   acc,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 done_cond
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;

  always_comb begin
    acc_next  = mplr[0] ? (acc + mcand) : acc;
    // Stop once no multiplier bits remain after this shift, or after the
    // final bit position has been consumed.
    done_cond = (mplr[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (load) begin
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, mcand_in};
      mplr  <= mplr_in;
      cnt   <= '0;
    end else if (run) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Memory-mapped iterative multiplier peripheral on the CPU data bus.
// A store to OPB starts a multiply of OPA by OPB; the 2*WIDTH-bit result
// appears in RESL/RESH, with BUSY/DONE/OVR status and a one-cycle IRQ.
// Ports:
//   CK    clock
//   RST   synchronous active-high reset
//   DA    data address
//   DDI   write data
//   DDO   read data, combinational mux of register state
//   RW    1 = read, 0 = write
//   SEL   DA falls in [BASE, BASE+4]
//   BUSY  multiply in progress
//   IRQ   one-cycle pulse when a new result is loaded
module mul_unit
  import mul_pkg::*;
#(
  parameter int            WIDTH  = 16,
  parameter int            AW     = 16,
  parameter logic [AW-1:0] BASE   = 'h70,
  parameter int            SIGNED = 0
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [AW-1:0]    DA,
  input  logic [WIDTH-1:0] DDI,
  output logic [WIDTH-1:0] DDO,
  input  logic             RW,
  output logic             SEL,
  output logic             BUSY,
  output logic             IRQ
);

  localparam bit SGN = (SIGNED != 0);

  // Magnitude of an operand; in signed mode the most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    if (SGN && sv < 0) return -v;
    return v;
  endfunction

  function automatic logic signed [2*WIDTH-1:0] apply_sign(
    input logic [2*WIDTH-1:0] mag,
    input logic               neg
  );
    return neg ? -mag : mag;
  endfunction

  logic [2:0]         off;
  logic               wr_en;
  logic               wr_opnd;

  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] res;
  logic               done;
  logic               ovr;
  logic               neg;
  logic [1:0]         state;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic               done_cond;

  assign off     = DA[2:0];
  // BASE is 8-aligned, so the upper address bits select the window.
  assign SEL     = (DA[AW-1:3] == BASE[AW-1:3]) && (off <= OFF_STAT);
  assign wr_en   = SEL && !RW;
  assign wr_opnd = wr_en && ((off == OFF_OPA) || (off == OFF_OPB));
  assign BUSY    = (state != ST_IDLE);

  mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (CK),
    .load      (state == ST_LOAD),
    .run       (state == ST_RUN),
    .mcand_in  (magnitude(opa)),
    .mplr_in   (magnitude(opb)),
    .acc       (acc),
    .acc_next  (acc_next),
    .done_cond (done_cond)
  );

  always_comb begin
    DDO = '0;
    if (SEL) begin
      case (off)
        OFF_OPA:  DDO = opa;
        OFF_OPB:  DDO = opb;
        OFF_RESL: DDO = res[WIDTH-1:0];
        OFF_RESH: DDO = res[2*WIDTH-1:WIDTH];
        OFF_STAT: begin
          DDO[STAT_BUSY] = BUSY;
          DDO[STAT_DONE] = done;
          DDO[STAT_OVR]  = ovr;
        end
        default:  DDO = '0;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state <= ST_IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      done  <= 1'b0;
      ovr   <= 1'b0;
      neg   <= 1'b0;
      IRQ   <= 1'b0;
    end else begin
      IRQ <= 1'b0;

      // Operand writes land only when idle; while busy they are dropped and
      // flagged, which also covers an OPB write on the completion edge.
      if (wr_opnd) begin
        if (BUSY) begin
          ovr <= 1'b1;
        end else if (off == OFF_OPA) begin
          opa <= DDI;
        end else begin
          opb <= DDI;
        end
      end

      if (wr_en && (off == OFF_STAT)) begin
        done <= 1'b0;
        ovr  <= 1'b0;
      end

      // Completion assignments come after the STAT clear so a new result
      // always reports DONE.
      case (state)
        ST_IDLE: begin
          if (wr_en && (off == OFF_OPB)) state <= ST_LOAD;
        end
        ST_LOAD: begin
          done  <= 1'b0;
          neg   <= SGN && (opa[WIDTH-1] ^ opb[WIDTH-1]);
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (done_cond) begin
            if (SGN) begin
              state <= ST_FIX;
            end else begin
              res   <= acc_next;
              done  <= 1'b1;
              IRQ   <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_FIX: begin
          res   <= apply_sign(acc, neg);
          done  <= 1'b1;
          IRQ   <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
